// File: rtl/wt_dcache_rd_arb_pkg.sv
// wt_dcache_rd_arb_pkg: shared dcache geometry, read-arbiter constants and compare-stage record
package wt_dcache_rd_arb_pkg;
  localparam int unsigned DCACHE_TAG_WIDTH = 20;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 6;
  localparam int unsigned DCACHE_RD_PORTS = 3;
  localparam int unsigned DCACHE_RD_STARVE_LIMIT = 16;
  typedef struct packed {
    logic vld;
    logic [DCACHE_RD_PORTS-1:0] port;
    logic [DCACHE_TAG_WIDTH-1:0] tag;
    logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] off;
    logic tag_only;
  } dcache_rd_cmp_t;
endpackage

// File: rtl/wt_dcache_rd_arb_if.sv
// wt_dcache_rd_arb_if: per-client read request bundle and one-hot ack
interface wt_dcache_rd_arb_if
  import wt_dcache_rd_arb_pkg::*;
#(
  parameter int unsigned NumPorts = DCACHE_RD_PORTS,
  parameter int unsigned TagWidth = DCACHE_TAG_WIDTH,
  parameter int unsigned IdxWidth = DCACHE_CL_IDX_WIDTH,
  parameter int unsigned OffWidth = DCACHE_OFFSET_WIDTH
);
  logic [NumPorts-1:0] rd_req;
  logic [NumPorts-1:0] rd_prio;
  logic [NumPorts-1:0] rd_tag_only;
  logic [NumPorts-1:0][TagWidth-1:0] rd_tag;
  logic [NumPorts-1:0][IdxWidth-1:0] rd_idx;
  logic [NumPorts-1:0][OffWidth-1:0] rd_off;
  logic [NumPorts-1:0] rd_ack;
  modport master (output rd_req, rd_prio, rd_tag_only, rd_tag, rd_idx, rd_off, input rd_ack);
  modport slave (input rd_req, rd_prio, rd_tag_only, rd_tag, rd_idx, rd_off, output rd_ack);
endinterface

// File: rtl/wt_dcache_rr_arb.sv
// wt_dcache_rr_arb: masked round-robin priority encoder, lowest request at or above ptr wins
module wt_dcache_rr_arb #(
  parameter int unsigned N = 3,
  localparam int unsigned PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  logic [N-1:0] mask;
  logic [N-1:0] masked;
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = i >= int'(ptr);
    masked = req & mask;
    gnt = |masked ? masked & (~masked + N'(1)) : req & (~req + N'(1));
  end
endmodule

// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb: dcache read-port arbiter with priority classes, starvation escalation
// and a one-cycle compare stage that flags refill collisions for replay.
module wt_dcache_rd_arb
  import wt_dcache_rd_arb_pkg::*;
#(
  parameter int unsigned NumPorts = DCACHE_RD_PORTS,
  parameter int unsigned TagWidth = DCACHE_TAG_WIDTH,
  parameter int unsigned IdxWidth = DCACHE_CL_IDX_WIDTH,
  parameter int unsigned OffWidth = DCACHE_OFFSET_WIDTH,
  parameter int unsigned StarveLimit = DCACHE_RD_STARVE_LIMIT
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  wt_dcache_rd_arb_if.slave   rd,
  input  logic                wr_cl_vld_i,
  input  logic [IdxWidth-1:0] wr_cl_idx_i,
  output logic                mem_rd_en_o,
  output logic                mem_tag_only_o,
  output logic [IdxWidth-1:0] mem_idx_o,
  output logic [OffWidth-1:0] mem_off_o,
  output logic [NumPorts-1:0] cmp_vld_o,
  output logic [TagWidth-1:0] cmp_tag_o,
  output logic [OffWidth-1:0] cmp_off_o,
  output logic                cmp_kill_o,
  output logic [NumPorts-1:0] escalated_o
);
  localparam int unsigned PW = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam int unsigned CW = $clog2(StarveLimit + 1);
  typedef struct packed {
    logic vld;
    logic [NumPorts-1:0] port;
    logic [TagWidth-1:0] tag;
    logic [IdxWidth-1:0] idx;
    logic [OffWidth-1:0] off;
  } cmp_t;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [NumPorts-1:0][CW-1:0] cnt;
  logic [NumPorts-1:0] esc;
  logic [NumPorts-1:0] hi_req;
  logic [NumPorts-1:0] gnt_hi;
  logic [NumPorts-1:0] gnt_all;
  logic [NumPorts-1:0] gnt;
  cmp_t stage;
  always_comb begin
    esc = '0;
    for (int i = 0; i < NumPorts; i++) esc[i] = cnt[i] == CW'(StarveLimit);
  end
  assign hi_req = rd.rd_req & (rd.rd_prio | esc);
  wt_dcache_rr_arb #(.N(NumPorts)) u_arb_hi (.req(hi_req), .ptr(rr_ptr), .gnt(gnt_hi));
  wt_dcache_rr_arb #(.N(NumPorts)) u_arb_all (.req(rd.rd_req), .ptr(rr_ptr), .gnt(gnt_all));
  // A refill owns the arrays this cycle, so it suppresses every grant.
  assign gnt = (!rst_ni || wr_cl_vld_i) ? '0 : |hi_req ? gnt_hi : gnt_all;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NumPorts; i++) if (gnt[i]) gidx = PW'(i);
  end
  assign rd.rd_ack = gnt;
  assign mem_rd_en_o = |gnt;
  assign mem_tag_only_o = rd.rd_tag_only[gidx];
  assign mem_idx_o = rd.rd_idx[gidx];
  assign mem_off_o = rd.rd_off[gidx];
  assign cmp_vld_o = (rst_ni && stage.vld) ? stage.port : '0;
  assign cmp_tag_o = rst_ni ? stage.tag : '0;
  assign cmp_off_o = rst_ni ? stage.off : '0;
  assign cmp_kill_o = rst_ni && stage.vld && wr_cl_vld_i && wr_cl_idx_i == stage.idx;
  assign escalated_o = rst_ni ? esc : '0;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      cnt <= '0;
      stage <= '0;
    end else begin
      if (|gnt) rr_ptr <= gidx == PW'(NumPorts - 1) ? '0 : gidx + PW'(1);
      for (int i = 0; i < NumPorts; i++)
        cnt[i] <= (!rd.rd_req[i] || gnt[i]) ? '0 :
                  (!rd.rd_prio[i] && cnt[i] != CW'(StarveLimit)) ? cnt[i] + CW'(1) : cnt[i];
      stage.vld <= |gnt;
      if (|gnt) begin
        stage.port <= gnt;
        stage.tag <= rd.rd_tag[gidx];
        stage.idx <= rd.rd_idx[gidx];
        stage.off <= rd.rd_off[gidx];
      end
    end
  end
endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// tb_wt_dcache_rd_arb: directed vectors for the dcache read arbiter (3-port and 5-port builds)
module tb_wt_dcache_rd_arb;
  import wt_dcache_rd_arb_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic wr_cl_vld;
  logic [7:0] wr_cl_idx;
  int n_cmp = 0;
  int n_err = 0;
  wt_dcache_rd_arb_if #(.NumPorts(3)) rif ();
  wt_dcache_rd_arb_if #(.NumPorts(5)) rif5 ();
  logic mem_rd_en, mem_tag_only, cmp_kill;
  logic [7:0] mem_idx;
  logic [5:0] mem_off, cmp_off;
  logic [2:0] cmp_vld, esc;
  logic [19:0] cmp_tag;
  logic mem_rd_en5, mem_tag_only5, cmp_kill5;
  logic [7:0] mem_idx5;
  logic [5:0] mem_off5, cmp_off5;
  logic [4:0] cmp_vld5, esc5;
  logic [19:0] cmp_tag5;
  wt_dcache_rd_arb #(.NumPorts(3), .StarveLimit(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd(rif.slave), .wr_cl_vld_i(wr_cl_vld), .wr_cl_idx_i(wr_cl_idx),
    .mem_rd_en_o(mem_rd_en), .mem_tag_only_o(mem_tag_only), .mem_idx_o(mem_idx), .mem_off_o(mem_off),
    .cmp_vld_o(cmp_vld), .cmp_tag_o(cmp_tag), .cmp_off_o(cmp_off), .cmp_kill_o(cmp_kill),
    .escalated_o(esc)
  );
  wt_dcache_rd_arb #(.NumPorts(5), .StarveLimit(1)) dut5 (
    .clk_i(clk), .rst_ni(rst_n), .rd(rif5.slave), .wr_cl_vld_i(wr_cl_vld), .wr_cl_idx_i(wr_cl_idx),
    .mem_rd_en_o(mem_rd_en5), .mem_tag_only_o(mem_tag_only5), .mem_idx_o(mem_idx5), .mem_off_o(mem_off5),
    .cmp_vld_o(cmp_vld5), .cmp_tag_o(cmp_tag5), .cmp_off_o(cmp_off5), .cmp_kill_o(cmp_kill5),
    .escalated_o(esc5)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] exp_ack;
    rst_n = 1'b0;
    wr_cl_vld = 1'b0;
    wr_cl_idx = 8'h00;
    rif.rd_req = 3'b111;
    rif.rd_prio = 3'b011;
    rif.rd_tag_only = 3'b000;
    rif.rd_tag[0] = 20'h00aaa;
    rif.rd_tag[1] = 20'h12345;
    rif.rd_tag[2] = 20'h00ccc;
    rif.rd_idx[0] = 8'h11;
    rif.rd_idx[1] = 8'h2a;
    rif.rd_idx[2] = 8'h33;
    rif.rd_off[0] = 6'h01;
    rif.rd_off[1] = 6'h05;
    rif.rd_off[2] = 6'h02;
    rif5.rd_req = '0;
    rif5.rd_prio = '0;
    rif5.rd_tag_only = '0;
    rif5.rd_tag = '0;
    rif5.rd_idx = '0;
    rif5.rd_off = '0;
    @(negedge clk);
    chk("rst_ack", rif.rd_ack, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_cmp_vld", cmp_vld, 0);
    chk("rst_kill", cmp_kill, 0);
    chk("rst_esc", esc, 0);
    chk("rst_cmp_tag", cmp_tag, 0);
    chk("rst_cmp_off", cmp_off, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      exp_ack = i == 16 ? 3'b100 : (i % 2 == 1 ? 3'b010 : 3'b001);
      chk($sformatf("starve_ack%0d", i), rif.rd_ack, exp_ack);
      chk($sformatf("starve_esc%0d", i), esc, i == 16 ? 3'b100 : 3'b000);
      if (i > 0) chk($sformatf("starve_cmp%0d", i), cmp_vld, i == 1 || i % 2 == 1 ? 3'b001 : 3'b010);
      step();
    end
    wr_cl_vld = 1'b1;
    wr_cl_idx = 8'h77;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("refill_ack%0d", j), rif.rd_ack, 0);
      chk($sformatf("refill_rd_en%0d", j), mem_rd_en, 0);
      chk($sformatf("refill_cmp%0d", j), cmp_vld, j == 0 ? 3'b100 : 3'b000);
      chk($sformatf("refill_kill%0d", j), cmp_kill, 0);
      step();
    end
    wr_cl_vld = 1'b0;
    @(negedge clk);
    chk("resume_ack0", rif.rd_ack, 3'b001);
    step();
    @(negedge clk);
    chk("resume_ack1", rif.rd_ack, 3'b010);
    step();
    rif.rd_req = 3'b010;
    @(negedge clk);
    chk("p1_ack", rif.rd_ack, 3'b010);
    chk("p1_mem_idx", mem_idx, 8'h2a);
    chk("p1_rd_en", mem_rd_en, 1);
    step();
    rif.rd_req = 3'b000;
    wr_cl_vld = 1'b1;
    wr_cl_idx = 8'h2a;
    @(negedge clk);
    chk("kill_cmp_vld", cmp_vld, 3'b010);
    chk("kill_hit", cmp_kill, 1);
    chk("kill_cmp_tag", cmp_tag, 20'h12345);
    chk("kill_cmp_off", cmp_off, 6'h05);
    chk("idle_mem_idx", mem_idx, 8'h11);
    step();
    wr_cl_vld = 1'b0;
    rif.rd_req = 3'b010;
    step();
    rif.rd_req = 3'b000;
    wr_cl_vld = 1'b1;
    wr_cl_idx = 8'h2b;
    @(negedge clk);
    chk("nokill_cmp_vld", cmp_vld, 3'b010);
    chk("nokill", cmp_kill, 0);
    step();
    wr_cl_vld = 1'b0;
    rif.rd_req = 3'b100;
    rif.rd_prio = 3'b000;
    rif.rd_tag_only = 3'b100;
    rif.rd_off[2] = 6'h18;
    @(negedge clk);
    chk("p2_ack", rif.rd_ack, 3'b100);
    chk("p2_tag_only", mem_tag_only, 1);
    chk("p2_mem_off", mem_off, 6'h18);
    step();
    rif.rd_req = 3'b000;
    @(negedge clk);
    chk("p2_cmp_vld", cmp_vld, 3'b100);
    chk("p2_cmp_off", cmp_off, 6'h18);
    step();
    rif.rd_req = 3'b111;
    rif.rd_prio = 3'b011;
    @(negedge clk);
    chk("pre_rst_ack", rif.rd_ack, 3'b001);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmp_vld", cmp_vld, 0);
    chk("mid_rst_ack", rif.rd_ack, 0);
    step();
    rst_n = 1'b1;
    rif.rd_prio = 3'b000;
    @(negedge clk);
    chk("post_rst_ack", rif.rd_ack, 3'b001);
    chk("post_rst_cmp_vld", cmp_vld, 0);
    chk("post_rst_esc", esc, 0);
    step();
    rif.rd_req = 3'b000;
    rif5.rd_req = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("p5_ack%0d", i), rif5.rd_ack, 5'b00001 << (i % 5));
      if (i == 1) chk("p5_esc1", esc5, 5'b11110);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
